// File: rtl/vwrite_burst.sv
// vwrite_burst: captures an accelerator stream into the unit's 2-port memory
// and, in the same run, drains the previously captured buffer to the databus
// as one write burst. In ping-pong mode capture and drain use opposite halves.
module vwrite_burst #(
  parameter int DATA_W     = 32,
  parameter int AXI_DATA_W = 32,
  parameter int ADDR_W     = 18,
  parameter int AXI_ADDR_W = 32,
  parameter int LEN_W      = 16,
  parameter int DELAY_W    = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic                    running,
  output logic                    done,
  input  logic [DATA_W-1:0]       in0,
  output logic                    databus_valid_0,
  input  logic                    databus_ready_0,
  output logic [AXI_ADDR_W-1:0]   databus_addr_0,
  output logic [AXI_DATA_W-1:0]   databus_wdata_0,
  output logic [AXI_DATA_W/8-1:0] databus_wstrb_0,
  output logic [LEN_W-1:0]        databus_len_0,
  input  logic                    databus_last_0,
  output logic                    ext_2p_write_0,
  output logic [ADDR_W-1:0]       ext_2p_addr_out_0,
  output logic [AXI_DATA_W-1:0]   ext_2p_data_out_0,
  output logic                    ext_2p_read_0,
  output logic [ADDR_W-1:0]       ext_2p_addr_in_0,
  input  logic [AXI_DATA_W-1:0]   ext_2p_data_in_0,
  input  logic [AXI_ADDR_W-1:0]   ext_addr,
  input  logic [LEN_W-1:0]        length,
  input  logic                    pingPong,
  input  logic                    enabled,
  input  logic [ADDR_W-1:0]       amount_minus_one,
  input  logic [ADDR_W-1:0]       capture_minus_one,
  input  logic [DELAY_W-1:0]      delay0
);
  localparam int LANES  = AXI_DATA_W / DATA_W;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int HALF_W = ADDR_W - 1;

  typedef enum logic [1:0] {C_IDLE, C_DELAY, C_CAPTURE, C_FLUSH} cap_st_t;
  typedef enum logic       {D_IDLE, D_BURST} drn_st_t;

  cap_st_t               cap_st;
  drn_st_t               drn_st;
  logic                  pp_state, pp_l, armed;
  logic [ADDR_W-1:0]     amt_m1_r, cap_m1_r;
  logic [DELAY_W-1:0]    dly_cnt;
  logic [ADDR_W-1:0]     cap_cnt, wr_idx, rd_idx;
  logic [LANE_W-1:0]     lane;
  logic [AXI_DATA_W-1:0] pack_buf, word_w, f0, f1, head;
  logic [1:0]            fcnt;
  logic                  rd_more, rd_vld, rd_issue, beat;
  logic                  cap_half, drn_half, cap_idle_nxt, drn_idle_nxt;
  logic [ADDR_W-1:0]     cap_wr_addr;

  assign cap_half    = pp_l & pp_state;
  assign drn_half    = pp_l & ~pp_state;
  assign cap_wr_addr = pp_l ? {cap_half, wr_idx[HALF_W-1:0]} : wr_idx;

  // Config is frozen for the whole run; the ping-pong bit flips per run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pp_state       <= 1'b0;
      pp_l           <= 1'b0;
      databus_addr_0 <= '0;
      databus_len_0  <= '0;
      amt_m1_r       <= '0;
      cap_m1_r       <= '0;
    end else if (run) begin
      pp_state       <= pingPong ? ~pp_state : 1'b0;
      pp_l           <= pingPong;
      databus_addr_0 <= ext_addr;
      databus_len_0  <= length;
      amt_m1_r       <= amount_minus_one;
      cap_m1_r       <= capture_minus_one;
    end
  end

  // Packer view of the current word with the incoming sample in its lane.
  always_comb begin
    word_w = pack_buf;
    for (int i = 0; i < LANES; i++)
      if (lane == LANE_W'(i)) word_w[i*DATA_W +: DATA_W] = in0;
  end

  // Capture FSM: delay, sample one word per cycle, pack, flush partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_st            <= C_IDLE;
      dly_cnt           <= '0;
      cap_cnt           <= '0;
      lane              <= '0;
      pack_buf          <= '0;
      wr_idx            <= '0;
      ext_2p_write_0    <= 1'b0;
      ext_2p_addr_out_0 <= '0;
      ext_2p_data_out_0 <= '0;
    end else begin
      ext_2p_write_0 <= 1'b0;
      if (!running || run) begin
        cap_st   <= !running ? C_IDLE : ((delay0 == '0) ? C_CAPTURE : C_DELAY);
        dly_cnt  <= delay0;
        cap_cnt  <= '0;
        lane     <= '0;
        pack_buf <= '0;
        wr_idx   <= '0;
      end else begin
        case (cap_st)
          C_DELAY: begin
            if (dly_cnt == DELAY_W'(1)) cap_st <= C_CAPTURE;
            else                        dly_cnt <= dly_cnt - 1'b1;
          end
          C_CAPTURE: begin
            if (lane == LANE_W'(LANES-1)) begin
              ext_2p_write_0    <= 1'b1;
              ext_2p_addr_out_0 <= cap_wr_addr;
              ext_2p_data_out_0 <= word_w;
              wr_idx            <= wr_idx + 1'b1;
              lane              <= '0;
              pack_buf          <= '0;
            end else begin
              pack_buf <= word_w;
              lane     <= lane + 1'b1;
            end
            if (cap_cnt == cap_m1_r) cap_st <= C_FLUSH;
            else                     cap_cnt <= cap_cnt + 1'b1;
          end
          C_FLUSH: begin
            if (lane != '0) begin
              ext_2p_write_0    <= 1'b1;
              ext_2p_addr_out_0 <= cap_wr_addr;
              ext_2p_data_out_0 <= pack_buf;
              wr_idx            <= wr_idx + 1'b1;
            end
            lane     <= '0;
            pack_buf <= '0;
            cap_st   <= C_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // Read data arriving this cycle is usable directly when the FIFO is empty,
  // which gives valid two cycles after run and one beat per cycle.
  assign head            = (fcnt != 2'd0) ? f0 : ext_2p_data_in_0;
  assign databus_valid_0 = (drn_st == D_BURST) && ((fcnt != 2'd0) || rd_vld);
  assign beat            = databus_valid_0 && databus_ready_0;
  assign databus_wdata_0 = databus_valid_0 ? head : '0;
  assign databus_wstrb_0 = databus_valid_0 ? '1 : '0;
  // Buffered plus in-flight never exceeds the two FIFO entries.
  assign rd_issue         = (drn_st == D_BURST) && rd_more &&
                            ((fcnt == 2'd0) || ((fcnt == 2'd1) && !rd_vld));
  assign ext_2p_read_0    = rd_issue;
  assign ext_2p_addr_in_0 = pp_l ? {drn_half, rd_idx[HALF_W-1:0]} : rd_idx;

  // Drain FSM: issue reads, keep the 2-entry FIFO, end on the last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drn_st  <= D_IDLE;
      rd_idx  <= '0;
      rd_more <= 1'b0;
      rd_vld  <= 1'b0;
      fcnt    <= 2'd0;
      f0      <= '0;
      f1      <= '0;
    end else if (!running || run) begin
      drn_st  <= (run && running && enabled && (length != '0)) ? D_BURST : D_IDLE;
      rd_idx  <= '0;
      rd_more <= run && running;
      rd_vld  <= 1'b0;
      fcnt    <= 2'd0;
    end else if (drn_st == D_BURST) begin
      rd_vld <= rd_issue;
      if (rd_issue) begin
        rd_idx <= rd_idx + 1'b1;
        if (rd_idx == amt_m1_r) rd_more <= 1'b0;
      end
      case (fcnt)
        2'd0: if (rd_vld && !beat) begin f0 <= ext_2p_data_in_0; fcnt <= 2'd1; end
        2'd1: begin
          if (beat && rd_vld) f0 <= ext_2p_data_in_0;
          else if (beat)      fcnt <= 2'd0;
          else if (rd_vld)    begin f1 <= ext_2p_data_in_0; fcnt <= 2'd2; end
        end
        default: if (beat) begin
          f0 <= f1;
          if (rd_vld) f1 <= ext_2p_data_in_0;
          else        fcnt <= 2'd1;
        end
      endcase
      if (beat && databus_last_0) begin
        drn_st  <= D_IDLE;
        rd_more <= 1'b0;
        rd_vld  <= 1'b0;
        fcnt    <= 2'd0;
      end
    end
  end

  assign cap_idle_nxt = (cap_st == C_IDLE) || (cap_st == C_FLUSH);
  assign drn_idle_nxt = (drn_st == D_IDLE) || (beat && databus_last_0);

  // done drops on run, and only a run that completes with running high sets it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done  <= 1'b1;
      armed <= 1'b0;
    end else if (run || !running) begin
      done  <= 1'b0;
      armed <= run && running;
    end else if (armed && cap_idle_nxt && drn_idle_nxt) begin
      done  <= 1'b1;
      armed <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vwrite_burst.sv
// Directed bench for vwrite_burst: capture, drain, backpressure, packing,
// ping-pong halves, reset and restart mid-burst.
module tb_vwrite_burst;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        run, b_run, running, pingPong, enabled;
  logic [31:0] ext_addr;
  logic [15:0] length;
  logic [17:0] amount_minus_one, capture_minus_one;
  logic [6:0]  delay0;
  logic [31:0] in0;
  logic [15:0] b_in0;

  logic        done, valid, ready, last, wr, rd;
  logic [31:0] addr, wdata, wdata_m, rdata;
  logic [3:0]  wstrb;
  logic [15:0] len;
  logic [17:0] waddr, raddr;

  logic        b_done, b_valid, b_wr, b_rd;
  logic [31:0] b_addr, b_wdata, b_wdata_m;
  logic [3:0]  b_wstrb;
  logic [15:0] b_len;
  logic [17:0] b_waddr, b_raddr;

  vwrite_burst dut (
    .clk(clk), .rst(rst), .run(run), .running(running), .done(done), .in0(in0),
    .databus_valid_0(valid), .databus_ready_0(ready), .databus_addr_0(addr),
    .databus_wdata_0(wdata), .databus_wstrb_0(wstrb), .databus_len_0(len),
    .databus_last_0(last), .ext_2p_write_0(wr), .ext_2p_addr_out_0(waddr),
    .ext_2p_data_out_0(wdata_m), .ext_2p_read_0(rd), .ext_2p_addr_in_0(raddr),
    .ext_2p_data_in_0(rdata), .ext_addr(ext_addr), .length(length),
    .pingPong(pingPong), .enabled(enabled), .amount_minus_one(amount_minus_one),
    .capture_minus_one(capture_minus_one), .delay0(delay0)
  );

  vwrite_burst #(.DATA_W(16)) dut_b (
    .clk(clk), .rst(rst), .run(b_run), .running(running), .done(b_done), .in0(b_in0),
    .databus_valid_0(b_valid), .databus_ready_0(1'b1), .databus_addr_0(b_addr),
    .databus_wdata_0(b_wdata), .databus_wstrb_0(b_wstrb), .databus_len_0(b_len),
    .databus_last_0(1'b0), .ext_2p_write_0(b_wr), .ext_2p_addr_out_0(b_waddr),
    .ext_2p_data_out_0(b_wdata_m), .ext_2p_read_0(b_rd), .ext_2p_addr_in_0(b_raddr),
    .ext_2p_data_in_0(32'h0), .ext_addr(ext_addr), .length(length),
    .pingPong(pingPong), .enabled(enabled), .amount_minus_one(amount_minus_one),
    .capture_minus_one(capture_minus_one), .delay0(delay0)
  );

  // Small memory model: half bit plus the low 4 address bits.
  logic [31:0] mem [32];
  function automatic int midx(input logic [17:0] a);
    return int'({a[17], a[3:0]});
  endfunction
  always @(posedge clk) begin
    if (wr) mem[midx(waddr)] <= wdata_m;
    if (rd) rdata <= mem[midx(raddr)];
  end

  int passed = 0, total = 0;

  logic [31:0] beats[$];
  int          first_k;
  bit          gap, ended, wr_seen, ok;
  logic [31:0] first_addr, wr_data_seen;
  logic [15:0] first_len;
  logic [3:0]  first_strb;
  logic [17:0] wr_addr_seen;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_run();
    tick(); run = 1'b1;
    tick(); run = 1'b0;
  endtask

  // Plays the interconnect: drives ready by pattern, raises last on the
  // expected final beat, records beats and the first memory write seen.
  task automatic collect(input int nb, input logic [3:0] rpat, input int maxc);
    bit started = 0;
    beats.delete(); first_k = -1; gap = 0; ended = 0; wr_seen = 0;
    for (int k = 0; k < maxc && !ended; k++) begin
      ready = rpat[k%4];
      last  = (beats.size() == nb - 1);
      #1;
      if (wr && !wr_seen) begin wr_seen = 1; wr_addr_seen = waddr; wr_data_seen = wdata_m; end
      if (valid) begin
        if (!started) begin
          started = 1; first_k = k; first_addr = addr; first_len = len; first_strb = wstrb;
        end
        if (ready) begin beats.push_back(wdata); if (last) ended = 1; end
      end else if (started) gap = 1;
      tick();
    end
    ready = 1'b0; last = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output bit got);
    got = 0;
    for (int i = 0; i < maxc; i++) begin
      if (done) begin got = 1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    #2;
    total++; if (done !== 1'b1)   $display("FAIL reset_done got %0b want 1", done); else passed++;
    total++; if (valid !== 1'b0)  $display("FAIL reset_valid got %0b want 0", valid); else passed++;
    total++; if (wr !== 1'b0)     $display("FAIL reset_write got %0b want 0", wr); else passed++;
    total++; if (rd !== 1'b0)     $display("FAIL reset_read got %0b want 0", rd); else passed++;
    total++; if (wstrb !== 4'h0)  $display("FAIL reset_wstrb got %h want 0", wstrb); else passed++;
    total++; if (wdata !== 32'h0) $display("FAIL reset_wdata got %h want 0", wdata); else passed++;
    total++; if (addr !== 32'h0 || len !== 16'h0)
      $display("FAIL reset_addr_len got %h/%h want 0/0", addr, len); else passed++;
    total++; if (waddr !== 18'h0 || raddr !== 18'h0)
      $display("FAIL reset_mem_addr got %h/%h want 0/0", waddr, raddr); else passed++;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_capture();
    pingPong = 0; enabled = 0; length = 0; amount_minus_one = 0;
    capture_minus_one = 3; delay0 = 0;
    pulse_run();
    for (int k = 1; k <= 7; k++) begin
      in0 = (k <= 4) ? 32'(32'hA0 + k - 1) : 32'hEE;
      #1;
      total++; if (wr !== (k >= 2 && k <= 5))
        $display("FAIL cap_write_T%0d got %0b want %0b", k, wr, (k >= 2 && k <= 5)); else passed++;
      if (k >= 2 && k <= 5) begin
        total++; if (waddr !== 18'(k - 2) || wdata_m !== 32'(32'hA0 + k - 2))
          $display("FAIL cap_word_T%0d got %h:%h want %h:%h", k, waddr, wdata_m, k - 2, 32'hA0 + k - 2);
        else passed++;
      end
      total++; if (done !== (k >= 6))
        $display("FAIL cap_done_T%0d got %0b want %0b", k, done, (k >= 6)); else passed++;
      tick();
    end
  endtask

  task automatic test_drain();
    enabled = 1; length = 16; amount_minus_one = 3; ext_addr = 32'h1000_0040;
    capture_minus_one = 0; delay0 = 40; in0 = 32'hA0;
    pulse_run();
    #1;
    total++; if (rd !== 1'b1 || raddr !== 18'h0)
      $display("FAIL drain_first_read got %0b@%h want 1@0", rd, raddr); else passed++;
    collect(4, 4'b1111, 20);
    total++; if (beats.size() !== 4) $display("FAIL drain_beats got %0d want 4", beats.size()); else passed++;
    for (int i = 0; i < beats.size() && i < 4; i++) begin
      total++; if (beats[i] !== 32'(32'hA0 + i))
        $display("FAIL drain_data%0d got %h want %h", i, beats[i], 32'hA0 + i); else passed++;
    end
    total++; if (first_k !== 1) $display("FAIL drain_first_valid got T+%0d want T+2", first_k + 1); else passed++;
    total++; if (first_addr !== 32'h1000_0040 || first_len !== 16'd16 || first_strb !== 4'hF)
      $display("FAIL drain_hdr got %h/%0d/%h want 10000040/16/f", first_addr, first_len, first_strb);
    else passed++;
    total++; if (gap !== 1'b0) $display("FAIL drain_gap got %0b want 0", gap); else passed++;
    #1;
    total++; if (valid !== 1'b0) $display("FAIL drain_valid_after got %0b want 0", valid); else passed++;
    wait_done(100, ok);
    total++; if (ok !== 1'b1) $display("FAIL drain_done got %0b want 1", ok); else passed++;
  endtask

  task automatic test_backpressure();
    pulse_run();
    collect(4, 4'b1001, 40);
    total++; if (ended !== 1'b1 || beats.size() !== 4)
      $display("FAIL bp_beats got %0d ended %0b want 4 ended 1", beats.size(), ended); else passed++;
    for (int i = 0; i < beats.size() && i < 4; i++) begin
      total++; if (beats[i] !== 32'(32'hA0 + i))
        $display("FAIL bp_data%0d got %h want %h", i, beats[i], 32'hA0 + i); else passed++;
    end
    total++; if (gap !== 1'b0) $display("FAIL bp_gap got %0b want 0", gap); else passed++;
    wait_done(100, ok);
    total++; if (ok !== 1'b1) $display("FAIL bp_done got %0b want 1", ok); else passed++;
  endtask

  task automatic test_pack16();
    enabled = 0; capture_minus_one = 2; delay0 = 0;
    tick(); b_run = 1'b1;
    tick(); b_run = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      b_in0 = (k <= 3) ? 16'(k) : 16'hFFFF;
      #1;
      total++; if (b_wr !== (k == 3 || k == 5))
        $display("FAIL pack_write_T%0d got %0b want %0b", k, b_wr, (k == 3 || k == 5)); else passed++;
      if (k == 3) begin
        total++; if (b_waddr !== 18'h0 || b_wdata_m !== 32'h0002_0001)
          $display("FAIL pack_word0 got %h:%h want 0:00020001", b_waddr, b_wdata_m); else passed++;
      end
      if (k == 5) begin
        total++; if (b_waddr !== 18'h1 || b_wdata_m !== 32'h0000_0003)
          $display("FAIL pack_flush got %h:%h want 1:00000003", b_waddr, b_wdata_m); else passed++;
      end
      if (k >= 4) begin
        total++; if (b_done !== (k == 5))
          $display("FAIL pack_done_T%0d got %0b want %0b", k, b_done, (k == 5)); else passed++;
      end
      tick();
    end
  endtask

  task automatic test_ping_pong();
    pingPong = 1; enabled = 0; capture_minus_one = 1; delay0 = 0;
    pulse_run();
    in0 = 32'hB0; tick();
    in0 = 32'hB1; #1;
    total++; if (wr !== 1'b1 || waddr !== 18'h20000 || wdata_m !== 32'hB0)
      $display("FAIL pp_cap0 got %0b %h:%h want 1 20000:b0", wr, waddr, wdata_m); else passed++;
    tick(); #1;
    total++; if (wr !== 1'b1 || waddr !== 18'h20001 || wdata_m !== 32'hB1)
      $display("FAIL pp_cap1 got %0b %h:%h want 1 20001:b1", wr, waddr, wdata_m); else passed++;
    wait_done(50, ok);
    total++; if (ok !== 1'b1) $display("FAIL pp_done1 got %0b want 1", ok); else passed++;
    enabled = 1; amount_minus_one = 1; length = 8; capture_minus_one = 0; in0 = 32'hC0;
    pulse_run();
    #1;
    total++; if (rd !== 1'b1 || raddr !== 18'h20000)
      $display("FAIL pp_read_half got %0b@%h want 1@20000", rd, raddr); else passed++;
    collect(2, 4'b1111, 20);
    total++; if (beats.size() !== 2) $display("FAIL pp_beats got %0d want 2", beats.size()); else passed++;
    for (int i = 0; i < beats.size() && i < 2; i++) begin
      total++; if (beats[i] !== 32'(32'hB0 + i))
        $display("FAIL pp_data%0d got %h want %h", i, beats[i], 32'hB0 + i); else passed++;
    end
    total++; if (wr_seen !== 1'b1 || wr_addr_seen !== 18'h0 || wr_data_seen !== 32'hC0)
      $display("FAIL pp_cap_half0 got %0b %h:%h want 1 0:c0", wr_seen, wr_addr_seen, wr_data_seen);
    else passed++;
    wait_done(50, ok);
    total++; if (ok !== 1'b1) $display("FAIL pp_done2 got %0b want 1", ok); else passed++;
  endtask

  task automatic test_reset_mid_burst();
    pingPong = 0; enabled = 1; amount_minus_one = 3; length = 16;
    capture_minus_one = 0; delay0 = 40; in0 = 32'hC0; ready = 0;
    pulse_run();
    tick(); tick(); #1;
    total++; if (valid !== 1'b1) $display("FAIL rstmid_pre_valid got %0b want 1", valid); else passed++;
    rst = 1'b1; #1;
    total++; if (valid !== 1'b0 || wstrb !== 4'h0)
      $display("FAIL rstmid_valid got %0b/%h want 0/0", valid, wstrb); else passed++;
    total++; if (done !== 1'b1) $display("FAIL rstmid_done got %0b want 1", done); else passed++;
    @(negedge clk) rst = 1'b0;
    tick(); #1;
    total++; if (done !== 1'b1 || valid !== 1'b0)
      $display("FAIL rstmid_after got %0b/%0b want 1/0", done, valid); else passed++;
  endtask

  task automatic test_back_to_back();
    ready = 0;
    pulse_run();
    tick(); tick();
    ready = 1; last = 0; #1;
    total++; if (valid !== 1'b1 || wdata !== 32'hC0)
      $display("FAIL restart_first_beat got %0b:%h want 1:c0", valid, wdata); else passed++;
    tick(); ready = 0; run = 1'b1;
    tick(); run = 1'b0; #1;
    total++; if (rd !== 1'b1 || raddr !== 18'h0 || valid !== 1'b0)
      $display("FAIL restart_read got %0b@%h valid %0b want 1@0 valid 0", rd, raddr, valid); else passed++;
    collect(4, 4'b1111, 20);
    total++; if (beats.size() !== 4) $display("FAIL restart_beats got %0d want 4", beats.size()); else passed++;
    for (int i = 0; i < beats.size() && i < 4; i++) begin
      total++; if (beats[i] !== ((i == 0) ? 32'hC0 : 32'(32'hA0 + i)))
        $display("FAIL restart_data%0d got %h want %h", i, beats[i], (i == 0) ? 32'hC0 : 32'hA0 + i);
      else passed++;
    end
    wait_done(100, ok);
    total++; if (ok !== 1'b1) $display("FAIL restart_done got %0b want 1", ok); else passed++;
  endtask

  initial begin
    rst = 1'b1; running = 1'b1; run = 1'b0; b_run = 1'b0; ready = 1'b0; last = 1'b0;
    pingPong = 0; enabled = 0; ext_addr = 0; length = 0; amount_minus_one = 0;
    capture_minus_one = 0; delay0 = 0; in0 = 0; b_in0 = 0;
    test_reset();
    test_capture();
    test_drain();
    test_backpressure();
    test_pack16();
    test_ping_pong();
    test_reset_mid_burst();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/vwrite_burst.md
# vwrite_burst

Write-side counterpart of the external-read unit: captures an accelerator data stream into the unit's 2-port internal memory and, in the same run, drains the previously captured buffer to external memory as one databus write burst. Ping-pong mode lets capture of run N overlap the drain of run N-1. Sits between the accelerator datapath and the shared databus interconnect.

## Interface
- DATA_W, 32, accelerator word width; AXI_DATA_W must be DATA_W times a power of two
- AXI_DATA_W, 32, databus and internal memory word width
- ADDR_W, 18, internal memory word address width; MSB is the ping-pong half bit
- AXI_ADDR_W, 32, external byte address width
- LEN_W, 16, burst length width in bytes
- DELAY_W, 7, capture start delay width
- clk  in  1  clock
- rst  in  1  reset rst, asynchronous, active-high
- run  in  1  single-cycle start pulse
- running  in  1  accelerator active; low forces drain and capture idle
- done  out  1  capture done AND drain done
- in0  in  DATA_W  accelerator data, sampled once per cycle during capture
- databus_valid_0  out  1  beat available
- databus_ready_0  in  1  beat accepted
- databus_addr_0  out  AXI_ADDR_W  burst start address, held for the burst
- databus_wdata_0  out  AXI_DATA_W  beat data
- databus_wstrb_0  out  AXI_DATA_W/8  all ones while valid, else 0
- databus_len_0  out  LEN_W  burst length in bytes
- databus_last_0  in  1  final beat marker from interconnect
- ext_2p_write_0 / ext_2p_addr_out_0 / ext_2p_data_out_0  out  1/ADDR_W/AXI_DATA_W  memory write port
- ext_2p_read_0 / ext_2p_addr_in_0  out  1/ADDR_W  memory read port
- ext_2p_data_in_0  in  AXI_DATA_W  read data, valid one cycle after read
- ext_addr, length, pingPong, enabled, amount_minus_one  in  config (Write stage), latched on run
- capture_minus_one  in  ADDR_W  DATA_W words to capture minus one
- delay0  in  DELAY_W  cycles from run to first sample

## Operation
- pingPongState: reset 0; on run toggles if pingPong else cleared. Capture half = pingPongState, drain half = !pingPongState when pingPong; both halves 0 otherwise (overlap hazard is software's responsibility).
- Capture FSM: IDLE -> DELAY (delay0 cycles) -> CAPTURE (capture_minus_one+1 samples, one per cycle) -> FLUSH -> IDLE. Packer fills lanes low-to-high; full word written to address 0,1,2… within capture half. FLUSH writes a partial word with unfilled lanes zero; skipped if empty.
- Drain FSM (started only if enabled && length!=0, else drain done immediately): IDLE -> BURST -> IDLE. Read counter issues reads from drain half addresses 0..amount_minus_one while (buffered + in-flight) < 2; 2-entry FIFO holds read data.
- databus_valid_0 = BURST && FIFO non-empty; wdata = FIFO head; beat on valid && ready pops head. Beat with databus_last_0 ends BURST.
- length must equal (amount_minus_one+1)*AXI_DATA_W/8; mismatch is undefined.
- run while busy: both FSMs restart, FIFO and packer flushed. running low: FSMs to IDLE, done stays low until next completed run.
- Reset values: done 1, all valid/write/read strobes 0, addresses/data/len 0, pingPongState 0.

## Timing
- Run cycle T: config latched at T; drain read issued at T+1, first databus_valid at T+2.
- First sample at T+1+delay0; memory write registered, asserted the cycle after the sample completing a word.
- Sustained one beat per cycle while ready held high (FIFO depth 2 covers read latency).
- done low from T+1; rises the cycle after both FSMs reach IDLE.
- Counters wrap modulo 2^(ADDR_W-1) inside a half when pingPong; no overflow check.

## Test plan
- DATA_W=AXI_DATA_W=32, pingPong=0, capture 4 words 0xA0..0xA3, delay0=0 -> writes at addr 0..3 cycles T+2..T+5; done at T+6.
- Next run, length=16, amount_minus_one=3, ready always 1 -> 4 beats wdata 0xA0..0xA3, addr=ext_addr, len=16, last on 4th; done after.
- Backpressure: ready toggles 1,0,0,1 -> no beat lost or duplicated, data order preserved, valid never drops mid-burst while FIFO non-empty.
- DATA_W=16, AXI_DATA_W=32, capture 3 samples 0x1,0x2,0x3 -> words 0x00020001 at 0, 0x00000003 at 1 (FLUSH).
- pingPong=1, two runs -> run1 captures half 1, run2 drains half 1 while capturing half 0; address MSB checked.
- rst asserted mid-burst -> valid 0 immediately, done 1; run asserted mid-burst -> burst restarts from address 0.
